msg_scroller: RTL and testbench



---
 rtl/msg_pkg.sv | 76 +++++++
 rtl/scroll_tick_gen.sv | 34 +++
 rtl/msg_scroller.sv | 111 +++++++++++
 tb/tb_msg_scroller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Character codes, message ROM and shared types for the seven-segment message scroller.
package msg_pkg;

    localparam logic [7:0] CH_A     = 8'h0A;
    localparam logic [7:0] CH_C     = 8'h0C;
    localparam logic [7:0] CH_D     = 8'h0D;
    localparam logic [7:0] CH_E     = 8'h1E;
    localparam logic [7:0] CH_I     = 8'hA0;
    localparam logic [7:0] CH_DASH  = 8'hA1;
    localparam logic [7:0] CH_P     = 8'hA2;
    localparam logic [7:0] CH_R     = 8'hA3;
    localparam logic [7:0] CH_U     = 8'hA4;
    localparam logic [7:0] CH_N     = 8'hA5;
    localparam logic [7:0] CH_T     = 8'hA6;
    localparam logic [7:0] CH_X     = 8'hA7;
    localparam logic [7:0] CH_O     = 8'hA8;
    localparam logic [7:0] CH_BLANK = 8'hA9;

    localparam logic [31:0] BLANK4 = {4{CH_BLANK}};

    localparam int unsigned IDX_W = 4;

    // Message lengths packed 4 bits per entry, message 0 in the low nibble.
    localparam logic [15:0] MSG_LEN_TBL = {4'd10, 4'd4, 4'd4, 4'd5};

    typedef enum logic {
        StIdle,
        StScroll
    } scroll_state_e;

    function automatic logic [IDX_W-1:0] msg_len(input logic [1:0] msg);
        return MSG_LEN_TBL[{msg, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] rom_char(input logic [1:0] msg, input logic [IDX_W-1:0] idx);
        logic [7:0] c;
        c = CH_BLANK;
        case (msg)
            2'd0: begin
                case (idx)
                    4'd0:    c = CH_P;
                    4'd1:    c = CH_R;
                    4'd2:    c = CH_I;
                    4'd3:    c = CH_N;
                    4'd4:    c = CH_T;
                    default: c = CH_BLANK;
                endcase
            end
            2'd1: begin
                case (idx)
                    4'd0:    c = CH_T;
                    4'd1:    c = CH_U;
                    4'd2:    c = CH_R;
                    4'd3:    c = CH_N;
                    default: c = CH_BLANK;
                endcase
            end
            2'd2: begin
                case (idx)
                    4'd0:    c = CH_D;
                    4'd1:    c = CH_A;
                    4'd2:    c = CH_T;
                    4'd3:    c = CH_O;
                    default: c = CH_BLANK;
                endcase
            end
            default: begin
                if (idx <= 4'd9) begin
                    c = {4'h0, idx};
                end
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-step prescaler: one tick every TICK_DIV enabled cycles, synchronous clear.
module scroll_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;
    logic             w_run;

    assign w_wrap = (r_cnt == CNT_MAX);
    // Clear takes priority so a stop in the tick cycle never produces a step.
    assign w_run  = i_enable && !i_clear;
    assign o_tick = w_run && w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls one of four ROM messages right-to-left across a 4-digit display word.
module msg_scroller
    import msg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [1:0]  i_msg_sel,
    input  logic        i_stop,
    input  logic        i_pause,
    input  logic        i_loop,
    output logic [31:0] o_x,
    output logic        o_busy,
    output logic        o_done
);

    scroll_state_e    r_state, w_state_nxt;
    logic [1:0]       r_msg, w_msg_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [31:0]      r_x, w_x_nxt;
    logic             r_done, w_done_nxt;

    logic             w_tick;
    logic             w_clear;
    logic             w_enable;
    logic [IDX_W-1:0] w_len;
    logic             w_last_step;
    logic [7:0]       w_char;

    assign w_clear  = (r_state != StScroll) || i_stop;
    assign w_enable = (r_state == StScroll) && !i_pause;

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_tick   (w_tick)
    );

    // Each pass shifts in L characters then four blanks to clear the display.
    assign w_len       = msg_len(r_msg);
    assign w_last_step = (r_idx == w_len + 4'd3);
    assign w_char      = (r_idx < w_len) ? rom_char(r_msg, r_idx) : CH_BLANK;

    always_comb begin
        w_state_nxt = r_state;
        w_msg_nxt   = r_msg;
        w_idx_nxt   = r_idx;
        w_x_nxt     = r_x;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start && !i_stop) begin
                    w_msg_nxt   = i_msg_sel;
                    w_idx_nxt   = '0;
                    w_x_nxt     = BLANK4;
                    w_state_nxt = StScroll;
                end
            end
            StScroll: begin
                if (i_stop) begin
                    w_x_nxt     = BLANK4;
                    w_state_nxt = StIdle;
                end else if (r_done) begin
                    // Stay busy through the done cycle, then release.
                    w_state_nxt = StIdle;
                end else if (w_tick) begin
                    w_x_nxt = {r_x[23:0], w_char};
                    if (w_last_step) begin
                        w_idx_nxt  = '0;
                        w_done_nxt = !i_loop;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_msg   <= '0;
            r_idx   <= '0;
            r_x     <= BLANK4;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_msg   <= w_msg_nxt;
            r_idx   <= w_idx_nxt;
            r_x     <= w_x_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_x    = r_x;
    assign o_busy = (r_state == StScroll);
    assign o_done = r_done;

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: vector table of scroll runs plus hand-written corner cases.
module tb_msg_scroller;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 3;
    localparam logic [31:0] BLANK    = 32'hA9A9A9A9;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_msg_sel;
    logic        i_stop;
    logic        i_pause;
    logic        i_loop;
    logic [31:0] o_x;
    logic        o_busy;
    logic        o_done;

    int n_total;
    int n_bad;

    logic [32:0] sb_q[$];

    typedef struct {
        logic [1:0] msg;
        logic       m_loop;
        int         nsteps;
        int         pause_at;
        logic       m_stop;
        logic       glitch;
    } vec_t;

    vec_t vecs[7];

    msg_scroller #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_msg_sel (i_msg_sel),
        .i_stop    (i_stop),
        .i_pause   (i_pause),
        .i_loop    (i_loop),
        .o_x       (o_x),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_len(input logic [1:0] m);
        case (m)
            2'd0:    return 5;
            2'd1:    return 4;
            2'd2:    return 4;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] tb_char(input logic [1:0] m, input int p);
        logic [79:0] t;
        case (m)
            2'd0:    t = 80'hA2A3A0A5A6;
            2'd1:    t = 80'hA6A4A3A5;
            2'd2:    t = 80'h0D0AA6A8;
            default: t = 80'h00010203040506070809;
        endcase
        return t[(tb_len(m) - 1 - p) * 8 +: 8];
    endfunction

    // Display word after k steps from a blank display.
    function automatic logic [31:0] exp_x(input logic [1:0] m, input logic lp, input int k);
        logic [31:0] x;
        int          pos;
        x = BLANK;
        for (int j = 0; j < k; j++) begin
            pos = lp ? (j % (tb_len(m) + 4)) : j;
            x   = {x[23:0], (pos < tb_len(m)) ? tb_char(m, pos) : 8'hA9};
        end
        return x;
    endfunction

    task automatic tick_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [32:0] e;
        logic [31:0] prev;
        i_msg_sel = v.msg;
        i_loop    = v.m_loop;
        i_start   = 1'b1;
        tick_sample();
        i_start   = 1'b0;
        i_msg_sel = v.msg ^ 2'b11;
        chk1("busy_after_start", o_busy, 1'b1);
        chk32("x_after_start", o_x, BLANK);
        for (int k = 1; k <= v.nsteps; k++) begin
            sb_q.push_back({(!v.m_loop && k == tb_len(v.msg) + 4), exp_x(v.msg, v.m_loop, k)});
        end
        prev = BLANK;
        for (int k = 1; k <= v.nsteps; k++) begin
            for (int c = 0; c < int'(TICK_DIV) - 1; c++) begin
                if (v.glitch && k == 2 && c == 0) begin
                    i_start   = 1'b1;
                    i_msg_sel = v.msg ^ 2'b01;
                end
                tick_sample();
                i_start = 1'b0;
                chk32("x_hold", o_x, prev);
                chk1("done_quiet", o_done, 1'b0);
            end
            tick_sample();
            e = sb_q.pop_front();
            chk32("x_step", o_x, e[31:0]);
            chk1("done_step", o_done, e[32]);
            chk1("busy_step", o_busy, 1'b1);
            prev = e[31:0];
            if (v.pause_at == k) begin
                i_pause = 1'b1;
                repeat (10) begin
                    tick_sample();
                    chk32("x_paused", o_x, prev);
                    chk1("busy_paused", o_busy, 1'b1);
                end
                i_pause = 1'b0;
            end
        end
        if (v.m_loop) begin
            chk32("loop_reentry", o_x, 32'hA9A9A9A2);
        end
        if (v.m_stop || v.m_loop) begin
            repeat (TICK_DIV - 1) begin
                tick_sample();
                chk32("x_hold_prestop", o_x, prev);
            end
            i_stop = 1'b1;
            tick_sample();
            i_stop = 1'b0;
            chk1("busy_after_stop", o_busy, 1'b0);
            chk32("x_after_stop", o_x, BLANK);
            chk1("done_after_stop", o_done, 1'b0);
        end else begin
            tick_sample();
            chk1("busy_after_done", o_busy, 1'b0);
            chk1("done_single", o_done, 1'b0);
            chk32("x_after_done", o_x, BLANK);
        end
        tick_sample();
        chk1("idle_busy", o_busy, 1'b0);
        chk32("idle_x", o_x, BLANK);
        i_loop = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b0;
        i_start   = 1'b0;
        i_msg_sel = 2'd0;
        i_stop    = 1'b0;
        i_pause   = 1'b0;
        i_loop    = 1'b0;

        vecs[0] = '{msg: 2'd1, m_loop: 1'b0, nsteps: 8,  pause_at: 0, m_stop: 1'b0, glitch: 1'b0};
        vecs[1] = '{msg: 2'd1, m_loop: 1'b0, nsteps: 8,  pause_at: 2, m_stop: 1'b0, glitch: 1'b0};
        vecs[2] = '{msg: 2'd3, m_loop: 1'b0, nsteps: 2,  pause_at: 0, m_stop: 1'b1, glitch: 1'b0};
        vecs[3] = '{msg: 2'd2, m_loop: 1'b0, nsteps: 8,  pause_at: 0, m_stop: 1'b0, glitch: 1'b1};
        vecs[4] = '{msg: 2'd0, m_loop: 1'b1, nsteps: 10, pause_at: 0, m_stop: 1'b0, glitch: 1'b0};
        vecs[5] = '{msg: 2'd3, m_loop: 1'b0, nsteps: 14, pause_at: 0, m_stop: 1'b0, glitch: 1'b0};
        vecs[6] = '{msg: 2'd0, m_loop: 1'b0, nsteps: 9,  pause_at: 0, m_stop: 1'b0, glitch: 1'b0};

        #2 reset = 1'b1;
        #1;
        chk32("reset_x", o_x, BLANK);
        chk1("reset_busy", o_busy, 1'b0);
        chk1("reset_done", o_done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick_sample();
        chk1("post_reset_busy", o_busy, 1'b0);

        // start and stop together in idle: stop wins
        i_start   = 1'b1;
        i_stop    = 1'b1;
        i_msg_sel = 2'd3;
        tick_sample();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk1("start_stop_busy", o_busy, 1'b0);
        repeat (TICK_DIV + 1) tick_sample();
        chk1("start_stop_busy_later", o_busy, 1'b0);
        chk32("start_stop_x", o_x, BLANK);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
        chk1("scoreboard_empty", sb_q.size() == 0, 1'b1);

        // asynchronous reset in the middle of a scroll
        i_msg_sel = 2'd3;
        i_start   = 1'b1;
        tick_sample();
        i_start = 1'b0;
        repeat (TICK_DIV + 1) tick_sample();
        chk32("pre_reset_x", o_x, exp_x(2'd3, 1'b0, 1));
        chk1("pre_reset_busy", o_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk32("async_reset_x", o_x, BLANK);
        chk1("async_reset_busy", o_busy, 1'b0);
        chk1("async_reset_done", o_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (TICK_DIV + 1) tick_sample();
        chk1("after_reset_idle", o_busy, 1'b0);
        chk32("after_reset_x", o_x, BLANK);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
